// File: rtl/cube_calc_pkg.sv
// Shared definitions for the cube calculator: FSM states, default width, latency.
package cube_calc_pkg;

  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    CUBE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Edges from acceptance until the result edge (inclusive).
  function automatic int unsigned latency(input int unsigned w);
    return 2 * w + 1;
  endfunction

  localparam int unsigned LATENCY = 2 * W_DEF + 1;

endpackage

// File: rtl/shift_add_mult.sv
// Sequential 2W-by-W shift-add multiplier with a 3W-bit accumulator.
module shift_add_mult
  import cube_calc_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic [3*W-1:0] acc,
  output logic [2*W-1:0] chain
);

  logic [3*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [3*W-1:0] sum;

  // Accumulator value after the pending bit; exposed low half lets the
  // caller reload the finished square without spending an extra edge.
  assign sum   = acc + (mplier[0] ? mcand : '0);
  assign chain = sum[2*W-1:0];

  // Operand load or one multiplier bit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/cube_calc.sv
// Computes x^3 as (x*x)*x by sequencing one shared shift-add multiplier.
module cube_calc
  import cube_calc_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   x_in,
  output logic [3*W-1:0] y_out,
  output logic           busy_o,
  output logic           done_o
);

  localparam int unsigned CW = $clog2(W + 1);

  state_t         state, state_nxt;
  logic [W-1:0]   x_reg;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           last;
  logic           m_load, m_step;
  logic [2*W-1:0] m_a;
  logic [W-1:0]   m_b;
  logic [3*W-1:0] m_acc;
  logic [2*W-1:0] m_chain;

  assign last = (cnt == CW'(W - 1));

  shift_add_mult #(.W(W)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .step  (m_step),
    .a     (m_a),
    .b     (m_b),
    .acc   (m_acc),
    .chain (m_chain)
  );

  // Next-state and multiplier control.
  // The final SQUARE bit is folded into the CUBE reload via m_chain, so
  // each phase spends exactly W edges.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    m_load    = 1'b0;
    m_step    = 1'b0;
    m_a       = '0;
    m_b       = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SQUARE;
          cnt_nxt   = '0;
          m_load    = 1'b1;
          m_a       = {{W{1'b0}}, x_in};
          m_b       = x_in;
        end
      end
      SQUARE: begin
        if (last) begin
          m_load    = 1'b1;
          m_a       = m_chain;
          m_b       = x_reg;
          cnt_nxt   = '0;
          state_nxt = CUBE;
        end else begin
          m_step  = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      CUBE: begin
        m_step = 1'b1;
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register, captured operand and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x_reg  <= '0;
      y_out  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_o <= 1'b0;
      if (state == IDLE && start) begin
        x_reg  <= x_in;
        busy_o <= 1'b1;
      end
      if (state == DONE) begin
        y_out  <= m_acc;
        busy_o <= 1'b0;
        done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cube_calc.sv
// Self-checking bench for cube_calc with a plain-arithmetic reference model.
module tb_cube_calc;
  import cube_calc_pkg::*;

  localparam int unsigned W = W_DEF;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   x_in;
  logic [3*W-1:0] y_out;
  logic           busy_o;
  logic           done_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cube_calc #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_in   (x_in),
    .y_out  (y_out),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint ref_cube(input longint x);
    return x * x * x;
  endfunction

  // Reference cube-root block: smallest r with r^3 >= y.
  function automatic int ref_cbrt(input longint y);
    int r = 0;
    while (ref_cube(r) < y) r++;
    return r;
  endfunction

  // One operation: pulse start, scramble x_in while busy, measure latency.
  task automatic do_op(input logic [W-1:0] x, output int lat, output int busy_cnt,
                       output logic [3*W-1:0] y);
    @(negedge clk);
    x_in  = x;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done_o && lat < 60) begin
      if (busy_o) busy_cnt++;
      x_in = W'($urandom);
      @(negedge clk);
      lat++;
    end
    y = y_out;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done x=%0d got=%b exp=0", x, busy_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL done_width x=%0d got=%b exp=0", x, done_o);
    end
  endtask

  task automatic check_op(input logic [W-1:0] x, input string tag);
    int lat, bc;
    logic [3*W-1:0] y;
    do_op(x, lat, bc, y);
    checks++;
    if (y !== (3*W)'(ref_cube(longint'(x)))) begin
      errors++;
      $display("FAIL %s_value x=%0d got=%0d exp=%0d", tag, x, y, ref_cube(longint'(x)));
    end
    checks++;
    if (lat != int'(LATENCY)) begin
      errors++;
      $display("FAIL %s_latency x=%0d got=%0d exp=%0d", tag, x, lat, LATENCY);
    end
    checks++;
    if (bc != int'(LATENCY)) begin
      errors++;
      $display("FAIL %s_busy_cycles x=%0d got=%0d exp=%0d", tag, x, bc, LATENCY);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; x_in = 8'd77;
    repeat (3) @(negedge clk);
    checks++;
    if (y_out !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%0d/%b/%b exp=0/0/0", y_out, busy_o, done_o);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] xs [5] = '{8'd0, 8'd1, 8'd2, 8'd6, 8'd255};
    foreach (xs[i]) check_op(xs[i], "directed");
    checks++;
    if (y_out !== 24'hFD02FF) begin
      errors++;
      $display("FAIL max_operand got=%h exp=fd02ff", y_out);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) check_op(W'($urandom), "random");
  endtask

  task automatic test_back_to_back;
    int t1, t2, n;
    @(negedge clk);
    x_in = 8'd3; start = 1'b1;
    n = 0;
    while (!busy_o && n < 10) begin @(negedge clk); n++; end
    t1   = cyc;
    x_in = 8'd4;
    n = 0;
    while (!done_o && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (y_out !== 24'd27) begin
      errors++;
      $display("FAIL b2b_first got=%0d exp=27", y_out);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!busy_o && n < 10);
    t2    = cyc;
    start = 1'b0;
    checks++;
    if (t2 - t1 != int'(LATENCY) + 1) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", t2 - t1, LATENCY + 1);
    end
    n = 0;
    while (!done_o && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (y_out !== 24'd64) begin
      errors++;
      $display("FAIL b2b_second got=%0d exp=64", y_out);
    end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    @(negedge clk);
    x_in = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    x_in = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ignore_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (y_out !== 24'd125) begin
      errors++;
      $display("FAIL ignore_value got=%0d exp=125", y_out);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle got=%b exp=0", busy_o);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    @(negedge clk);
    x_in = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || y_out !== '0) begin
      errors++;
      $display("FAIL midreset_state got=%b/%0d exp=0/0", busy_o, y_out);
    end
    for (int i = 0; i < 30; i++) begin
      if (done_o) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0 || y_out !== '0) begin
      errors++;
      $display("FAIL midreset_nodone got=%0d/%0d exp=0/0", pulses, y_out);
    end
    check_op(8'd9, "after_reset");
  endtask

  task automatic test_roundtrip;
    int lat, bc;
    logic [3*W-1:0] y;
    for (int i = 0; i <= 6; i++) begin
      do_op(W'(i), lat, bc, y);
      checks++;
      if (ref_cbrt(longint'(y)) != i) begin
        errors++;
        $display("FAIL roundtrip i=%0d got=%0d exp=%0d", i, ref_cbrt(longint'(y)), i);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_in = '0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    test_roundtrip;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
